// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor
//
// Measures the frequency of a PLL-derived toggle by counting its edges over a
// fixed gate window of the reference clock. Reports each window's edge count,
// whether the count is within tolerance, and whether the clock looks dead.
// Lock is declared after LOCK_WINDOWS consecutive in-range windows.
//
// Ports
//   clk_i         reference clock, all logic on its rising edge
//   rst_i         synchronous reset, active-high, overrides everything
//   en_i          measurement enable
//   meas_tog_i    divided toggle from the PLL domain (asynchronous)
//   freq_count_o  edge count of the last reported window
//   freq_valid_o  one-cycle pulse when count/in_range/dead update
//   in_range_o    last reported window within EXP_COUNT +/- TOL
//   dead_o        last reported window counted zero edges
//   freq_ok_o     lock indication
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_UNLOCKED | no lock; waiting for the first in-range report
// ST_ACQUIRE  | lock_cnt consecutive in-range reports seen so far
// ST_LOCKED   | LOCK_WINDOWS consecutive in-range reports; freq_ok high

module clk_freq_monitor #(
    parameter int GATE_CYCLES  = 27000,
    parameter int EXP_COUNT    = 7500,
    parameter int TOL          = 75,
    parameter int LOCK_WINDOWS = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             meas_tog_i,
    output logic [CNT_W-1:0] freq_count_o,
    output logic             freq_valid_o,
    output logic             in_range_o,
    output logic             dead_o,
    output logic             freq_ok_o
);

    localparam int GC_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int LC_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GC_W-1:0] GATE_LAST = GC_W'(GATE_CYCLES - 1);
    // Lower bound clamps at zero rather than wrapping negative.
    localparam int LO_INT = (EXP_COUNT > TOL) ? (EXP_COUNT - TOL) : 0;
    localparam logic [CNT_W:0] LO_BOUND = (CNT_W + 1)'(LO_INT);
    localparam logic [CNT_W:0] HI_BOUND = (CNT_W + 1)'(EXP_COUNT + TOL);
    localparam logic [LC_W-1:0] LOCK_TARGET = LC_W'(LOCK_WINDOWS);
    localparam logic [LC_W-1:0] LOCK_ONE    = LC_W'(1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    logic             sync_s1_q, sync_s2_q, sync_s3_q;
    logic             tog_edge;
    logic [GC_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             armed_q, armed_d;
    state_t           state_q, state_d;
    logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] freq_count_q;
    logic             freq_valid_q, in_range_q, dead_q;

    logic             window_end;
    logic             report;
    logic [CNT_W-1:0] captured;
    logic [CNT_W:0]   cap_wide;
    logic             cap_in_range;

    // Both toggle polarities count, so each input transition is one edge.
    assign tog_edge = sync_s2_q ^ sync_s3_q;

    assign window_end = en_i && (gate_cnt_q == GATE_LAST);
    // armed_q is clear for the first window after reset or enable, which
    // hides synchronizer fill and a spurious edge when the toggle starts high.
    assign report     = window_end && armed_q;

    // Saturating edge_cnt + edge; also serves as the running increment.
    assign captured     = (tog_edge && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    assign cap_wide     = {1'b0, captured};
    assign cap_in_range = (cap_wide >= LO_BOUND) && (cap_wide <= HI_BOUND);

    always_comb begin
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        armed_d    = armed_q;
        if (!en_i) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            armed_d    = 1'b0;
        end else if (window_end) begin
            // Edge on this cycle is already folded into captured.
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            armed_d    = 1'b1;
        end else begin
            gate_cnt_d = gate_cnt_q + GC_W'(1);
            edge_cnt_d = captured;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (!en_i) begin
            state_d    = ST_UNLOCKED;
            lock_cnt_d = '0;
        end else if (report) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (cap_in_range) begin
                        lock_cnt_d = LOCK_ONE;
                        state_d    = (LOCK_TARGET <= LOCK_ONE) ? ST_LOCKED : ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (cap_in_range) begin
                        lock_cnt_d = lock_cnt_q + LOCK_ONE;
                        if ((lock_cnt_q + LOCK_ONE) >= LOCK_TARGET) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        lock_cnt_d = '0;
                        state_d    = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!cap_in_range) begin
                        lock_cnt_d = '0;
                        state_d    = ST_UNLOCKED;
                    end
                end
                default: begin
                    lock_cnt_d = '0;
                    state_d    = ST_UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_s1_q    <= 1'b0;
            sync_s2_q    <= 1'b0;
            sync_s3_q    <= 1'b0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            armed_q      <= 1'b0;
            state_q      <= ST_UNLOCKED;
            lock_cnt_q   <= '0;
            freq_count_q <= '0;
            freq_valid_q <= 1'b0;
            in_range_q   <= 1'b0;
            dead_q       <= 1'b0;
        end else begin
            sync_s1_q    <= meas_tog_i;
            sync_s2_q    <= sync_s1_q;
            sync_s3_q    <= sync_s2_q;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            freq_valid_q <= report;
            if (report) begin
                freq_count_q <= captured;
                in_range_q   <= cap_in_range;
                dead_q       <= (captured == '0);
            end
        end
    end

    assign freq_count_o = freq_count_q;
    assign freq_valid_o = freq_valid_q;
    assign in_range_o   = in_range_q;
    assign dead_o       = dead_q;
    assign freq_ok_o    = (state_q == ST_LOCKED);

endmodule
